// File: rtl/lcd_ctrl_pkg.sv
// Shared LCD controller definitions.
// Holds the fetch FSM state type, the column/word geometry and the frame marker
// used to bracket every expanded column.
package lcd_ctrl_pkg;

  localparam int unsigned LCD_COL_W  = 64;
  localparam int unsigned RAM_WORD_W = 10;
  localparam int unsigned EXPAND_W   = 6;

  localparam logic [1:0] FRAME_MARK = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StWait,
    StPresent,
    StDone
  } fetch_state_e;

endpackage

// File: rtl/lcd_column_fetch_ctrl_if.sv
// Bus between the column fetch controller and its environment (frame RAM read
// port, LCD column writer, frame control).
//   master : controller side (drives RAM address/strobe and the column stream)
//   slave  : environment side (drives start/abort, RAM data and col_ready)
interface lcd_column_fetch_ctrl_if #(
  parameter int unsigned ADDR_W = 7
);
  import lcd_ctrl_pkg::*;

  logic                  start;
  logic                  abort;
  logic [ADDR_W-1:0]     ram_addr;
  logic                  ram_rd_en;
  logic [RAM_WORD_W-1:0] ram_data;
  logic [LCD_COL_W-1:0]  col_data;
  logic                  col_valid;
  logic                  col_ready;
  logic [ADDR_W-1:0]     col_index;
  logic                  busy;
  logic                  frame_done;

  modport master (
    input  start, abort, ram_data, col_ready,
    output ram_addr, ram_rd_en, col_data, col_valid, col_index, busy, frame_done
  );

  modport slave (
    output start, abort, ram_data, col_ready,
    input  ram_addr, ram_rd_en, col_data, col_valid, col_index, busy, frame_done
  );

endinterface

// File: rtl/lcd_col_expand.sv
// Combinational RAM-word to LCD-column expansion.
//   i_word : RAM word, one bit per 6-pixel group
//   o_col  : {FRAME_MARK, e9..e0, FRAME_MARK}, ek = 6 copies of i_word[k]
module lcd_col_expand
  import lcd_ctrl_pkg::*;
(
  input  logic [RAM_WORD_W-1:0] i_word,
  output logic [LCD_COL_W-1:0]  o_col
);

  always_comb begin
    o_col = '0;
    o_col[LCD_COL_W-1 -: 2] = FRAME_MARK;
    o_col[1:0]              = FRAME_MARK;
    for (int k = 0; k < RAM_WORD_W; k++) begin
      o_col[2 + k*EXPAND_W +: EXPAND_W] = {EXPAND_W{i_word[k]}};
    end
  end

endmodule

// File: rtl/lcd_column_fetch_ctrl.sv
// Frame sequencer: on start reads NUM_COLS frame-RAM words in order, expands
// each into a framed 64-bit column and hands it to the LCD writer over
// valid/ready; pulses frame_done after the last column is accepted.
//   i_clk  : system clock
//   i_rst  : asynchronous active-high reset
//   io_bus : master side of lcd_column_fetch_ctrl_if
module lcd_column_fetch_ctrl
  import lcd_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W   = 7,
  parameter int unsigned NUM_COLS = 64,
  parameter int unsigned RAM_LAT  = 1
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  lcd_column_fetch_ctrl_if.master         io_bus
);

  localparam logic [ADDR_W-1:0] LastCol  = ADDR_W'(NUM_COLS - 1);
  localparam logic [1:0]        LastWait = 2'(RAM_LAT - 1);

  fetch_state_e          r_state;
  fetch_state_e          w_state_next;
  logic [ADDR_W-1:0]     r_addr;
  logic [1:0]            r_lat_cnt;
  logic [LCD_COL_W-1:0]  r_col_data;
  logic [ADDR_W-1:0]     r_col_index;
  logic [LCD_COL_W-1:0]  w_expanded;
  logic                  w_abort;
  logic                  w_start;
  logic                  w_last_wait;
  logic                  w_handshake;

  // abort only acts on a running frame; in IDLE it also masks start
  assign w_abort     = (r_state != StIdle) && io_bus.abort;
  assign w_start     = (r_state == StIdle) && io_bus.start && !io_bus.abort;
  assign w_last_wait = (r_lat_cnt == LastWait);
  assign w_handshake = (r_state == StPresent) && io_bus.col_ready;

  lcd_col_expand u_expand (
    .i_word (io_bus.ram_data),
    .o_col  (w_expanded)
  );

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; abort overrides everything including a handshake
  always_comb begin
    w_state_next = r_state;
    if (w_abort) begin
      w_state_next = StIdle;
    end else begin
      unique case (r_state)
        StIdle:    if (w_start) w_state_next = StRead;
        StRead:    w_state_next = StWait;
        StWait:    if (w_last_wait) w_state_next = StPresent;
        StPresent: begin
          if (w_handshake) begin
            w_state_next = (r_addr == LastCol) ? StDone : StRead;
          end
        end
        StDone:    w_state_next = StIdle;
        default:   w_state_next = StIdle;
      endcase
    end
  end

  // Moore outputs
  always_comb begin
    io_bus.ram_rd_en  = 1'b0;
    io_bus.col_valid  = 1'b0;
    io_bus.busy       = 1'b1;
    io_bus.frame_done = 1'b0;
    unique case (r_state)
      StIdle:    io_bus.busy       = 1'b0;
      StRead:    io_bus.ram_rd_en  = 1'b1;
      StWait:    ;
      StPresent: io_bus.col_valid  = 1'b1;
      StDone:    io_bus.frame_done = 1'b1;
      default:   io_bus.busy       = 1'b0;
    endcase
  end

  assign io_bus.ram_addr  = r_addr;
  assign io_bus.col_data  = r_col_data;
  assign io_bus.col_index = r_col_index;

  // Address counter, latency counter and column registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_addr      <= '0;
      r_lat_cnt   <= '0;
      r_col_data  <= '0;
      r_col_index <= '0;
    end else begin
      if (w_abort || w_start || r_state == StDone) begin
        r_addr <= '0;
      end else if (w_handshake && r_addr != LastCol) begin
        r_addr <= r_addr + ADDR_W'(1);
      end

      if (r_state == StWait && !w_last_wait && !w_abort) begin
        r_lat_cnt <= r_lat_cnt + 2'd1;
      end else begin
        r_lat_cnt <= '0;
      end

      // ram_data is only trusted on the final WAIT cycle
      if (r_state == StWait && w_last_wait) begin
        r_col_data  <= w_expanded;
        r_col_index <= r_addr;
      end
    end
  end

endmodule

// File: tb/tb_lcd_column_fetch_ctrl.sv
module tb_lcd_column_fetch_ctrl;
  import lcd_ctrl_pkg::*;

  localparam int unsigned ADDR_W   = 7;
  localparam int unsigned NUM_COLS = 64;
  localparam int          BIG      = 32'h7fff_ffff;

  logic clk = 1'b0;
  logic rst;
  logic tb_start, tb_abort, tb_ready;
  logic [9:0] tb_junk;
  logic [9:0] mem [128];

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  lcd_column_fetch_ctrl_if #(.ADDR_W(ADDR_W)) bus0 ();
  lcd_column_fetch_ctrl_if #(.ADDR_W(ADDR_W)) bus1 ();

  lcd_column_fetch_ctrl #(.ADDR_W(ADDR_W), .NUM_COLS(NUM_COLS), .RAM_LAT(1)) dut_l1 (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus0)
  );

  lcd_column_fetch_ctrl #(.ADDR_W(ADDR_W), .NUM_COLS(NUM_COLS), .RAM_LAT(3)) dut_l3 (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus1)
  );

  assign bus0.start     = tb_start;
  assign bus0.abort     = tb_abort;
  assign bus0.col_ready = tb_ready;
  assign bus1.start     = tb_start;
  assign bus1.abort     = tb_abort;
  assign bus1.col_ready = tb_ready;

  // RAM models: data valid exactly RAM_LAT cycles after the strobe, junk otherwise
  logic [10:0] rp0;
  logic [10:0] rp1 [3];
  always_ff @(posedge clk) begin
    rp0    <= {bus0.ram_rd_en, mem[bus0.ram_addr]};
    rp1[0] <= {bus1.ram_rd_en, mem[bus1.ram_addr]};
    rp1[1] <= rp1[0];
    rp1[2] <= rp1[1];
  end
  assign bus0.ram_data = (rp0[10] === 1'b1) ? rp0[9:0] : tb_junk;
  assign bus1.ram_data = (rp1[2][10] === 1'b1) ? rp1[2][9:0] : tb_junk;

  logic [ADDR_W-1:0] o_addr  [2];
  logic              o_rd    [2];
  logic [63:0]       o_data  [2];
  logic              o_valid [2];
  logic [ADDR_W-1:0] o_index [2];
  logic              o_busy  [2];
  logic              o_done  [2];
  assign o_addr[0]  = bus0.ram_addr;   assign o_addr[1]  = bus1.ram_addr;
  assign o_rd[0]    = bus0.ram_rd_en;  assign o_rd[1]    = bus1.ram_rd_en;
  assign o_data[0]  = bus0.col_data;   assign o_data[1]  = bus1.col_data;
  assign o_valid[0] = bus0.col_valid;  assign o_valid[1] = bus1.col_valid;
  assign o_index[0] = bus0.col_index;  assign o_index[1] = bus1.col_index;
  assign o_busy[0]  = bus0.busy;       assign o_busy[1]  = bus1.busy;
  assign o_done[0]  = bus0.frame_done; assign o_done[1]  = bus1.frame_done;

  // Reference model: per DUT, which column is due, and the cycles at which the
  // strobe, the column and frame_done are due, from the latency rules.
  int m_act [2], m_idx [2], m_rcyc [2], m_vcyc [2], m_done [2], m_end [2];
  int obs_fv [2], obs_fd [2], obs_hs [2];

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic logic [63:0] expand_ref(input logic [9:0] w);
    logic [63:0] v;
    for (int i = 0; i < 64; i++) v[i] = (i < 2 || i >= 62) ? 1'b1 : w[(i - 2) / 6];
    return v;
  endfunction

  function automatic logic exp_valid(input int d);
    return (m_act[d] != 0) && (cyc >= m_vcyc[d]);
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, got, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s cycle %0d: bound expired", name, cyc);
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_act[d] = 0; m_idx[d] = 0; m_rcyc[d] = -1; m_vcyc[d] = BIG;
      m_done[d] = -1; m_end[d] = -1;
    end
  endtask

  task automatic clear_obs();
    for (int d = 0; d < 2; d++) begin
      obs_fv[d] = -1; obs_fd[d] = -1; obs_hs[d] = 0;
    end
  endtask

  task automatic check_dut(input int d);
    logic ev, er;
    if (m_act[d] != 0 && m_end[d] == cyc) m_act[d] = 0;
    er = (m_act[d] != 0) && (m_rcyc[d] == cyc);
    ev = exp_valid(d);
    chk($sformatf("busy%0d", d), 64'(o_busy[d]), 64'(m_act[d] != 0));
    chk($sformatf("rd_en%0d", d), 64'(o_rd[d]), 64'(er));
    if (er) chk($sformatf("ram_addr%0d", d), 64'(o_addr[d]), 64'(m_idx[d]));
    chk($sformatf("col_valid%0d", d), 64'(o_valid[d]), 64'(ev));
    chk($sformatf("frame_done%0d", d), 64'(o_done[d]), 64'(m_done[d] == cyc));
    if (ev) begin
      chk($sformatf("col_index%0d", d), 64'(o_index[d]), 64'(m_idx[d]));
      chk($sformatf("col_data%0d", d), o_data[d], expand_ref(mem[m_idx[d]]));
    end
    if (o_valid[d] && obs_fv[d] < 0) obs_fv[d] = cyc;
    if (o_done[d] && obs_fd[d] < 0) obs_fd[d] = cyc;
  endtask

  task automatic model_update(input int d, input logic s, input logic a, input logic r);
    logic ev;
    ev = exp_valid(d);
    if (o_valid[d] && r) obs_hs[d]++;
    if (m_act[d] != 0 && a) begin
      m_act[d] = 0; m_done[d] = -1;
    end else if (m_act[d] == 0 && s && !a) begin
      m_act[d] = 1; m_idx[d] = 0; m_rcyc[d] = cyc + 1; m_vcyc[d] = cyc + 2 + lat_of(d);
      m_done[d] = -1; m_end[d] = -1;
    end else if (ev && r) begin
      if (m_idx[d] == NUM_COLS - 1) begin
        m_done[d] = cyc + 1; m_end[d] = cyc + 2; m_vcyc[d] = BIG; m_rcyc[d] = -1;
      end else begin
        m_idx[d]++; m_rcyc[d] = cyc + 1; m_vcyc[d] = cyc + 2 + lat_of(d);
      end
    end
  endtask

  // One clock cycle: check this cycle's outputs, drive inputs sampled at its end
  task automatic cycle(input logic s, input logic a, input logic r);
    for (int d = 0; d < 2; d++) check_dut(d);
    tb_start = s; tb_abort = a; tb_ready = r; tb_junk = 10'($urandom);
    for (int d = 0; d < 2; d++) model_update(d, s, a, r);
    @(negedge clk);
    cyc++;
  endtask

  task automatic rand_mem();
    for (int i = 0; i < 128; i++) mem[i] = 10'($urandom);
  endtask

  task automatic check_all_zero(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk({tag, "_addr"}, 64'(o_addr[d]), 64'd0);
      chk({tag, "_rd"}, 64'(o_rd[d]), 64'd0);
      chk({tag, "_data"}, o_data[d], 64'd0);
      chk({tag, "_valid"}, 64'(o_valid[d]), 64'd0);
      chk({tag, "_index"}, 64'(o_index[d]), 64'd0);
      chk({tag, "_busy"}, 64'(o_busy[d]), 64'd0);
      chk({tag, "_done"}, 64'(o_done[d]), 64'd0);
    end
  endtask

  typedef struct {
    logic [9:0]  word;
    logic [63:0] col;
  } vec_t;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tv [5];
    int   c0, k, rdcnt;
    tv[0] = '{10'h000, 64'hC000_0000_0000_0003};
    tv[1] = '{10'h3FF, 64'hFFFF_FFFF_FFFF_FFFF};
    tv[2] = '{10'h200, 64'hFF00_0000_0000_0003};
    tv[3] = '{10'h001, 64'hC000_0000_0000_00FF};
    tv[4] = '{10'h002, 64'hC000_0000_0000_3F03};

    rand_mem();
    tb_start = 0; tb_abort = 0; tb_ready = 0; tb_junk = '0;
    rst = 1'b1;
    model_reset();
    clear_obs();
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // Expansion table: column 0 held under backpressure, then aborted
    for (int t = 0; t < 5; t++) begin
      mem[0] = tv[t].word;
      cycle(1, 0, 0);
      for (k = 0; k < 10 && !(exp_valid(0) && exp_valid(1)); k++) cycle(0, 0, 0);
      if (!(exp_valid(0) && exp_valid(1))) timeout("table_wait");
      chk($sformatf("table%0d_l1", t), o_data[0], tv[t].col);
      chk($sformatf("table%0d_l3", t), o_data[1], tv[t].col);
      cycle(0, 1, 0);
      cycle(0, 0, 0);
    end

    // Abort with start in IDLE: stays idle
    cycle(1, 1, 0);
    chk("abort_start_idle_l1", 64'(o_busy[0]), 64'd0);
    chk("abort_start_idle_l3", 64'(o_busy[1]), 64'd0);
    cycle(0, 0, 0);

    // Full frame, ready held high, extra starts while busy
    rand_mem();
    clear_obs();
    c0 = cyc;
    cycle(1, 0, 1);
    for (k = 0; k < 400 && (m_act[0] != 0 || m_act[1] != 0); k++) begin
      cycle((k >= 1 && k <= 3) || k == 100, 0, 1);
    end
    if (m_act[0] != 0 || m_act[1] != 0) timeout("full_frame");
    chk("first_valid_l1", 64'(obs_fv[0] - c0), 64'd3);
    chk("first_valid_l3", 64'(obs_fv[1] - c0), 64'd5);
    chk("frame_done_l1", 64'(obs_fd[0] - c0), 64'd193);
    chk("frame_done_l3", 64'(obs_fd[1] - c0), 64'd321);
    chk("handshakes_l1", 64'(obs_hs[0]), 64'd64);
    chk("handshakes_l3", 64'(obs_hs[1]), 64'd64);
    cycle(0, 0, 0);

    // Backpressure for 10 cycles, then advance
    cycle(1, 0, 0);
    for (k = 0; k < 10 && !(exp_valid(0) && exp_valid(1)); k++) cycle(0, 0, 0);
    if (!(exp_valid(0) && exp_valid(1))) timeout("bp_wait");
    rdcnt = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(0, 0, 0);
      if (o_rd[0] || o_rd[1]) rdcnt++;
    end
    chk("bp_no_rd_en", 64'(rdcnt), 64'd0);
    cycle(0, 0, 1);
    repeat (5) cycle(0, 0, 0);
    chk("bp_advance_l1", 64'(o_index[0]), 64'd1);
    chk("bp_advance_l3", 64'(o_index[1]), 64'd1);
    cycle(0, 1, 0);
    cycle(0, 0, 0);

    // Abort coinciding with the handshake of column 5
    cycle(1, 0, 1);
    for (k = 0; k < 100 && !(m_idx[0] == 5 && exp_valid(0)); k++) cycle(0, 0, 1);
    if (!(m_idx[0] == 5 && exp_valid(0))) timeout("abort_wait");
    cycle(0, 1, 1);
    chk("abort_valid", 64'(o_valid[0]), 64'd0);
    chk("abort_busy", 64'(o_busy[0]), 64'd0);
    repeat (3) cycle(0, 0, 0);
    cycle(1, 0, 1);
    chk("restart_rd_en", 64'(o_rd[0]), 64'd1);
    chk("restart_addr", 64'(o_addr[0]), 64'd0);

    // Asynchronous reset while presenting
    for (k = 0; k < 10 && !exp_valid(0); k++) cycle(0, 0, 0);
    if (!exp_valid(0)) timeout("rst_wait");
    for (int d = 0; d < 2; d++) check_dut(d);
    tb_start = 0; tb_abort = 0; tb_ready = 0;
    #2 rst = 1'b1;
    #1 check_all_zero("async_rst");
    model_reset();
    @(negedge clk);
    cyc++;
    rst = 1'b0;
    cycle(1, 0, 1);
    chk("post_rst_rd_en", 64'(o_rd[0]), 64'd1);
    for (k = 0; k < 400 && (m_act[0] != 0 || m_act[1] != 0); k++) cycle(0, 0, 1);
    if (m_act[0] != 0 || m_act[1] != 0) timeout("post_rst_frame");

    // Randomized traffic against the model
    rand_mem();
    for (int i = 0; i < 4000; i++) begin
      cycle(($urandom % 12) == 0, ($urandom % 60) == 0, 1'($urandom));
    end
    for (k = 0; k < 10; k++) cycle(0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
